// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache memory-side blocks.
//   wb_state_t    : write buffer FSM state encoding
//   CACHE_ADDR_W  : default address width
//   CACHE_DATA_W  : default data width
package cache_pkg;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_READ  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/write_buffer_l1.sv
// Posted-write buffer between the L1 cache memory port and main memory.
// Cache writes are queued in a DEPTH-entry FIFO and drained to memory in
// issue order. Cache reads that match a queued address are answered from
// the youngest matching entry; other reads go to memory.
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   c_ce/c_rw/c_addr/c_wdata  cache request (c_rw=1 read)
//   c_rdata, c_hold        read data, stall back to the cache
//   m_ce/m_rw/m_addr/m_wdata  memory request
//   m_rdata, m_ready       memory read data, access-complete strobe
//   wb_empty, wb_count     FIFO occupancy
//   dbg_state              current FSM state, for observation only
//
// Handshakes: the cache presents c_ce and keeps the request stable while
// c_hold=1; the request is consumed on the first posedge with c_hold=0.
// The memory request (m_ce and its qualifiers) stays frozen until a
// posedge with m_ready=1, which completes it.
import cache_pkg::*;

module write_buffer_l1 #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c_ce,
  input  logic                     c_rw,
  input  logic [ADDR_W-1:0]        c_addr,
  input  logic [DATA_W-1:0]        c_wdata,
  output logic [DATA_W-1:0]        c_rdata,
  output logic                     c_hold,
  output logic                     m_ce,
  output logic                     m_rw,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_ready,
  output logic                     wb_empty,
  output logic [$clog2(DEPTH):0]   wb_count,
  output wb_state_t                dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  wb_state_t         state_q, state_d;

  logic              read_req, write_req;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  idx;
  logic              read_miss, full, nonempty;
  logic              own_read, own_drain;
  logic              read_done, drain_done;
  logic              push, pop;

  assign read_req  = rst & c_ce & c_rw;
  assign write_req = rst & c_ce & ~c_rw;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign nonempty  = (count_q != '0);

  // Forwarding compare over every entry, walked oldest to youngest so the
  // youngest match is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && addr_q[idx] == c_addr) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign read_miss = read_req & ~hit;

  // Port ownership is decided combinationally so a zero-wait read from
  // IDLE completes in its first cycle. Once a state is registered the
  // owner is locked until m_ready, which keeps the memory request frozen.
  assign own_read  = rst & ((state_q == WB_READ) |
                            ((state_q == WB_IDLE) & read_miss));
  assign own_drain = rst & ((state_q == WB_DRAIN) |
                            ((state_q == WB_IDLE) & nonempty & ~read_miss));

  assign read_done  = own_read  & m_ready;
  assign drain_done = own_drain & m_ready;

  assign m_ce    = own_read | own_drain;
  assign m_rw    = own_read;
  assign m_addr  = own_read ? c_addr : (own_drain ? addr_q[head_q] : '0);
  assign m_wdata = own_drain ? data_q[head_q] : '0;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    c_hold = 1'b0;
    if (write_req)      c_hold = full & ~drain_done;
    else if (read_miss) c_hold = ~read_done;
  end

  always_comb begin
    c_rdata = '0;
    if (read_req && hit) c_rdata = hit_data;
    else if (read_done)  c_rdata = m_rdata;
  end

  assign push = write_req & ~c_hold;
  assign pop  = drain_done;

  always_comb begin
    state_d = WB_IDLE;
    if (own_read)       state_d = m_ready ? WB_IDLE : WB_READ;
    else if (own_drain) state_d = m_ready ? WB_IDLE : WB_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      // Pop before push: when full, head and tail alias and the new entry
      // must end up valid.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= c_addr;
      data_q[tail_q] <= c_wdata;
    end
  end

  assign wb_empty  = ~rst | ~nonempty;
  assign wb_count  = rst ? count_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_write_buffer_l1.sv
// Self-checking bench for write_buffer_l1: a table of single-cycle vectors
// plus hand-written multi-cycle sequences, with a memory model and an
// ordered scoreboard of expected memory writes.
import cache_pkg::*;

module tb_write_buffer_l1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        c_ce = 1'b0, c_rw = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [31:0] c_rdata;
  logic        c_hold;
  logic        m_ce, m_rw;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ready = 1'b0;
  logic        wb_empty;
  logic [2:0]  wb_count;
  wb_state_t   dbg_state;

  write_buffer_l1 dut (
    .clk(clk), .rst(rst),
    .c_ce(c_ce), .c_rw(c_rw), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_hold(c_hold),
    .m_ce(m_ce), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .wb_empty(wb_empty), .wb_count(wb_count), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model + scoreboard ----------------
  logic [31:0] mem [logic [31:0]];
  logic [63:0] exp_q[$];

  assign m_rdata = (m_ce && m_rw) ? (32'h1000_0000 + {24'd0, m_addr[9:2]}) : 32'd0;

  always @(posedge clk) begin
    if (rst && m_ce && !m_rw && m_ready) begin
      mem[m_addr] = m_wdata;
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_write", {m_addr, m_wdata}, 64'd0);
      end else begin
        chk("mem_write_order", {m_addr, m_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs at the negedge; outputs settle by the return.
  task automatic drive(input logic ce, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic mr);
    @(negedge clk);
    c_ce = ce; c_rw = rw; c_addr = addr; c_wdata = wdata; m_ready = mr;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; c_ce = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain_all(input string name);
    int n;
    n = 0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    while (!wb_empty && n < 50) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      n++;
    end
    chk(name, {63'd0, wb_empty}, 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ce, rw;
    logic [31:0] addr, wdata;
    logic        mr;
    logic        hold;
    logic [31:0] rdata;
    logic        mce;
    logic [31:0] maddr;
    logic [2:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic ce, logic rw, logic [31:0] addr, logic [31:0] wdata,
                              logic mr, logic hold, logic [31:0] rdata, logic mce,
                              logic [31:0] maddr, logic [2:0] cnt);
    vec_t v;
    v.ce = ce; v.rw = rw; v.addr = addr; v.wdata = wdata; v.mr = mr;
    v.hold = hold; v.rdata = rdata; v.mce = mce; v.maddr = maddr; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    int n;
    // ce rw addr wdata mr | hold rdata mce maddr count(before edge)
    vecs[0]  = mk(1, 0, 32'hA0, 32'd1, 0,  0, 32'd0, 0, 32'h00, 3'd0);
    vecs[1]  = mk(1, 0, 32'hA4, 32'd2, 0,  0, 32'd0, 1, 32'hA0, 3'd1);
    vecs[2]  = mk(1, 0, 32'hA8, 32'd3, 0,  0, 32'd0, 1, 32'hA0, 3'd2);
    vecs[3]  = mk(1, 0, 32'hAC, 32'd4, 0,  0, 32'd0, 1, 32'hA0, 3'd3);
    vecs[4]  = mk(1, 0, 32'hB0, 32'd5, 0,  1, 32'd0, 1, 32'hA0, 3'd4);
    vecs[5]  = mk(1, 0, 32'hB0, 32'd5, 1,  0, 32'd0, 1, 32'hA0, 3'd4);
    vecs[6]  = mk(1, 1, 32'hA8, 32'd0, 0,  0, 32'd3, 1, 32'hA4, 3'd4);
    vecs[7]  = mk(1, 1, 32'hB0, 32'd0, 0,  0, 32'd5, 1, 32'hA4, 3'd4);
    vecs[8]  = mk(1, 1, 32'hA4, 32'd0, 0,  0, 32'd2, 1, 32'hA4, 3'd4);
    vecs[9]  = mk(0, 0, 32'h00, 32'd0, 1,  0, 32'd0, 1, 32'hA4, 3'd4);
    vecs[10] = mk(0, 0, 32'h00, 32'd0, 1,  0, 32'd0, 1, 32'hA8, 3'd3);
    vecs[11] = mk(0, 0, 32'h00, 32'd0, 1,  0, 32'd0, 1, 32'hAC, 3'd2);
    vecs[12] = mk(0, 0, 32'h00, 32'd0, 1,  0, 32'd0, 1, 32'hB0, 3'd1);
    vecs[13] = mk(0, 0, 32'h00, 32'd0, 0,  0, 32'd0, 0, 32'h00, 3'd0);

    // ---- reset state ----
    @(negedge clk); #2;
    chk("rst_m_ce", {63'd0, m_ce}, 64'd0);
    chk("rst_c_hold", {63'd0, c_hold}, 64'd0);
    chk("rst_c_rdata", {32'd0, c_rdata}, 64'd0);
    chk("rst_wb_empty", {63'd0, wb_empty}, 64'd1);
    @(negedge clk); rst = 1'b1; #2;
    chk("rst_wb_count", {61'd0, wb_count}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, WB_IDLE});

    // ---- table: fill to full, full-with-drain, forwarding, drain out ----
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ce, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].mr);
      chk($sformatf("vec%0d_hold", i), {63'd0, c_hold}, {63'd0, vecs[i].hold});
      chk($sformatf("vec%0d_rdata", i), {32'd0, c_rdata}, {32'd0, vecs[i].rdata});
      chk($sformatf("vec%0d_mce", i), {63'd0, m_ce}, {63'd0, vecs[i].mce});
      if (vecs[i].mce) chk($sformatf("vec%0d_maddr", i), {32'd0, m_addr}, {32'd0, vecs[i].maddr});
      chk($sformatf("vec%0d_count", i), {61'd0, wb_count}, {61'd0, vecs[i].cnt});
      if (vecs[i].ce && !vecs[i].rw && !vecs[i].hold) exp_q.push_back({vecs[i].addr, vecs[i].wdata});
    end
    chk("table_mem_B0", {32'd0, mem[32'hB0]}, 64'd5);

    // ---- 1: single write, zero-wait memory ----
    do_reset();
    drive(1, 0, 32'h20, 32'hDEADBEEF, 1);
    exp_q.push_back({32'h20, 32'hDEADBEEF});
    chk("t1_no_mce_yet", {63'd0, m_ce}, 64'd0);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("t1_m_ce", {63'd0, m_ce}, 64'd1);
    chk("t1_m_rw", {63'd0, m_rw}, 64'd0);
    chk("t1_m_addr", {32'd0, m_addr}, 64'h20);
    chk("t1_m_wdata", {32'd0, m_wdata}, 64'hDEADBEEF);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("t1_empty", {63'd0, wb_empty}, 64'd1);
    chk("t1_idle_mce", {63'd0, m_ce}, 64'd0);

    // ---- 3: same-address writes, forward youngest, drain oldest ----
    do_reset();
    drive(1, 0, 32'h40, 32'd1, 0); exp_q.push_back({32'h40, 32'd1});
    drive(1, 0, 32'h40, 32'd2, 0); exp_q.push_back({32'h40, 32'd2});
    drive(1, 1, 32'h40, 32'd0, 0);
    chk("t3_rdata", {32'd0, c_rdata}, 64'd2);
    chk("t3_hold", {63'd0, c_hold}, 64'd0);
    chk("t3_m_addr", {32'd0, m_addr}, 64'h40);
    chk("t3_m_wdata", {32'd0, m_wdata}, 64'd1);
    drain_all("t3_drained");

    // ---- 4: read miss arriving during a stalled drain ----
    do_reset();
    drive(1, 0, 32'h60, 32'd7, 0); exp_q.push_back({32'h60, 32'd7});
    drive(0, 0, 32'h0, 32'h0, 0);
    chk("t4_drain_started", {63'd0, m_ce}, 64'd1);
    drive(1, 1, 32'h80, 32'd0, 0);
    chk("t4_hold_in_drain", {63'd0, c_hold}, 64'd1);
    chk("t4_still_write", {63'd0, m_rw}, 64'd0);
    drive(1, 1, 32'h80, 32'd0, 1);
    chk("t4_hold_drain_done", {63'd0, c_hold}, 64'd1);
    drive(1, 1, 32'h80, 32'd0, 0);
    chk("t4_read_rw", {63'd0, m_rw}, 64'd1);
    chk("t4_read_addr", {32'd0, m_addr}, 64'h80);
    chk("t4_read_hold", {63'd0, c_hold}, 64'd1);
    drive(1, 1, 32'h80, 32'd0, 1);
    chk("t4_rdata", {32'd0, c_rdata}, 64'h1000_0020);
    chk("t4_hold_released", {63'd0, c_hold}, 64'd0);
    drive(0, 0, 32'h0, 32'h0, 0);
    chk("t4_back_idle", {62'd0, dbg_state}, {62'd0, WB_IDLE});

    // ---- 5: reset abandons pending writes ----
    do_reset();
    drive(1, 0, 32'hC0, 32'd11, 0);
    drive(1, 0, 32'hC4, 32'd12, 0);
    drive(1, 0, 32'hC8, 32'd13, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    chk("t5_count3", {61'd0, wb_count}, 64'd3);
    chk("t5_drain_stalled", {62'd0, dbg_state}, {62'd0, WB_DRAIN});
    @(negedge clk);
    rst = 1'b0; #2;
    chk("t5_rst_m_ce", {63'd0, m_ce}, 64'd0);
    chk("t5_rst_empty", {63'd0, wb_empty}, 64'd1);
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b1; #2;
    chk("t5_count0", {61'd0, wb_count}, 64'd0);
    chk("t5_empty", {63'd0, wb_empty}, 64'd1);
    chk("t5_m_ce", {63'd0, m_ce}, 64'd0);
    for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 32'h0, 1);

    // ---- 6: ordering with random wait states ----
    do_reset();
    begin
      logic [31:0] wa [3];
      logic [31:0] wd [3];
      wa[0] = 32'h10; wa[1] = 32'h14; wa[2] = 32'h10;
      wd[0] = 32'd1;  wd[1] = 32'd2;  wd[2] = 32'd3;
      for (int k = 0; k < 3; k++) begin
        n = 0;
        drive(1, 0, wa[k], wd[k], 1'($urandom_range(0, 1)));
        while (c_hold && n < 50) begin
          drive(1, 0, wa[k], wd[k], 1'($urandom_range(0, 1)));
          n++;
        end
        chk($sformatf("t6_accept%0d", k), {63'd0, c_hold}, 64'd0);
        exp_q.push_back({wa[k], wd[k]});
      end
      n = 0;
      drive(0, 0, 32'h0, 32'h0, 1'($urandom_range(0, 1)));
      while (!wb_empty && n < 200) begin
        drive(0, 0, 32'h0, 32'h0, 1'($urandom_range(0, 1)));
        n++;
      end
      chk("t6_drained", {63'd0, wb_empty}, 64'd1);
      @(negedge clk);
      chk("t6_mem10", {32'd0, mem[32'h10]}, 64'd3);
      chk("t6_mem14", {32'd0, mem[32'h14]}, 64'd2);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
